// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V memory stage: funct3 codes,
// exception cause encodings, FSM states and access-legality helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE       = 2'b00;
    localparam logic [1:0] EXC_MISALIGNED = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

    // Access size comes from funct3[1:0]: 00 byte, 01 halfword, 10 word.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // A memory op is illegal if it claims to be both a load and a store,
    // or if its funct3 is not one of the defined widths for its direction.
    function automatic logic is_illegal(input logic       is_load,
                                        input logic       is_store,
                                        input logic [2:0] funct3);
        logic ill;
        ill = 1'b0;
        if (is_load && is_store) begin
            ill = 1'b1;
        end else if (is_load) begin
            ill = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU));
        end else if (is_store) begin
            ill = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        end
        return ill;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: builds store strobes/replicated write data and
// extracts and extends load data from the returned memory word.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Store side: replicate the operand across lanes and enable only the addressed bytes.
    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
        case (st_size_i)
            2'b00: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_addr_lo_i;
            end
            2'b01: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wstrb_o = 4'b0011 << st_addr_lo_i;
            end
            default: begin
                st_wdata_o = st_data_i;
                st_wstrb_o = 4'b1111;
            end
        endcase
    end

    // Load side: pick the addressed byte/halfword and extend it according to funct3.
    always_comb begin
        ldByte = ld_rdata_i[7:0];
        case (ld_addr_lo_i)
            2'b00:   ldByte = ld_rdata_i[7:0];
            2'b01:   ldByte = ld_rdata_i[15:8];
            2'b10:   ldByte = ld_rdata_i[23:16];
            default: ldByte = ld_rdata_i[31:24];
        endcase
        ldHalf = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ldByte[7]}}, ldByte};
            F3_BU:   ld_data_o = {24'h000000, ldByte};
            F3_H:    ld_data_o = {{16{ldHalf[15]}}, ldHalf};
            F3_HU:   ld_data_o = {16'h0000, ldHalf};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/riscv_mem_stage.sv
// Memory stage: accepts ALU results, runs loads/stores over a valid/ready
// memory port, and produces one writeback or exception pulse per op.
module riscv_mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_valid,
    output logic [1:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr
);

    mem_state_e      state_q;
    logic            isLoad_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic            we_q;
    logic [RD_W-1:0] rd_q;
    logic            regWrite_q;
    logic            reqValid_q;
    logic            wbValid_q;
    logic            wbWe_q;
    logic [RD_W-1:0] wbRd_q;
    logic [XLEN-1:0] wbData_q;
    logic            excValid_q;
    logic [1:0]      excCause_q;
    logic [XLEN-1:0] excAddr_q;

    logic [31:0] stWdata_d;
    logic [3:0]  stWstrb_d;
    logic [31:0] ldData_d;
    logic        isMemOp;
    logic        misaligned;
    logic        illegal;

    riscv_lsu_align u_align (
        .st_size_i    (ex_funct3[1:0]),
        .st_addr_lo_i (ex_result[1:0]),
        .st_data_i    (ex_store_data),
        .st_wdata_o   (stWdata_d),
        .st_wstrb_o   (stWstrb_d),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_q[1:0]),
        .ld_rdata_i   (mem_rdata),
        .ld_data_o    (ldData_d)
    );

    assign isMemOp    = ex_is_load || ex_is_store;
    assign misaligned = is_misaligned(ex_funct3[1:0], ex_result[1:0]);
    assign illegal    = is_illegal(ex_is_load, ex_is_store, ex_funct3);

    // Mem-stage FSM plus all latched operands and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            isLoad_q   <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            we_q       <= 1'b0;
            rd_q       <= '0;
            regWrite_q <= 1'b0;
            reqValid_q <= 1'b0;
            wbValid_q  <= 1'b0;
            wbWe_q     <= 1'b0;
            wbRd_q     <= '0;
            wbData_q   <= '0;
            excValid_q <= 1'b0;
            excCause_q <= EXC_NONE;
            excAddr_q  <= '0;
        end else begin
            wbValid_q  <= 1'b0;
            excValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (!isMemOp) begin
                            wbValid_q <= 1'b1;
                            wbWe_q    <= ex_reg_write && (ex_rd != '0);
                            wbRd_q    <= ex_rd;
                            wbData_q  <= ex_result;
                        end else if (misaligned) begin
                            excValid_q <= 1'b1;
                            excCause_q <= EXC_MISALIGNED;
                            excAddr_q  <= ex_result;
                        end else if (illegal) begin
                            excValid_q <= 1'b1;
                            excCause_q <= EXC_ILLEGAL;
                            excAddr_q  <= ex_result;
                        end else begin
                            isLoad_q   <= ex_is_load;
                            funct3_q   <= ex_funct3;
                            addr_q     <= ex_result;
                            we_q       <= ex_is_store;
                            wdata_q    <= ex_is_store ? stWdata_d : '0;
                            wstrb_q    <= ex_is_store ? stWstrb_d : 4'b0000;
                            rd_q       <= ex_rd;
                            regWrite_q <= ex_reg_write;
                            reqValid_q <= 1'b1;
                            state_q    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        reqValid_q <= 1'b0;
                        we_q       <= 1'b0;
                        wstrb_q    <= 4'b0000;
                        if (isLoad_q) begin
                            state_q <= ST_RESP;
                        end else begin
                            wbValid_q <= 1'b1;
                            wbWe_q    <= 1'b0;
                            wbRd_q    <= rd_q;
                            wbData_q  <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid) begin
                        wbValid_q <= 1'b1;
                        wbWe_q    <= regWrite_q && (rd_q != '0);
                        wbRd_q    <= rd_q;
                        wbData_q  <= ldData_d;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ex_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = reqValid_q;
    assign mem_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign mem_we        = we_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;
    assign wb_valid      = wbValid_q;
    assign wb_we         = wbWe_q;
    assign wb_rd         = wbRd_q;
    assign wb_data       = wbData_q;
    assign exc_valid     = excValid_q;
    assign exc_cause     = excCause_q;
    assign exc_addr      = excAddr_q;

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Directed, table-driven bench for riscv_mem_stage: loads, stores,
// exceptions, back-to-back ALU ops, request stalls and reset mid-load.
module tb_riscv_mem_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] expData;
    } loadVec_t;

    typedef struct {
        logic        isLoad;
        logic        isStore;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [1:0]  expCause;
    } excVec_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
        logic        expWe;
    } aluVec_t;

    loadVec_t loadVecs[7];
    excVec_t  excVecs[7];
    aluVec_t  aluVecs[4];

    riscv_mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_funct3     (ex_funct3),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .exc_addr      (exc_addr)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic isLoad,
                                 input logic isStore, input logic [2:0] f3,
                                 input logic [31:0] result, input logic [31:0] sdata,
                                 input logic [4:0] rd, input logic regWrite);
        ex_valid      = valid;
        ex_is_load    = isLoad;
        ex_is_store   = isStore;
        ex_funct3     = f3;
        ex_result     = result;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = regWrite;
    endtask

    task automatic doLoad(input loadVec_t v);
        applyStimulus(1'b1, 1'b1, 1'b0, v.funct3, v.addr, 32'h0, 5'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("ld req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("ld mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        checkOutput("ld mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("ld wstrb", {28'b0, mem_wstrb}, 32'd0);
        checkOutput("ld ex_ready", {31'b0, ex_ready}, 32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checkOutput("ld resp req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("ld resp wb_valid", {31'b0, wb_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("ld wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("ld wb_data", wb_data, v.expData);
        checkOutput("ld wb_we", {31'b0, wb_we}, 32'd1);
        checkOutput("ld wb_rd", {27'b0, wb_rd}, 32'd5);
        checkOutput("ld back idle", {31'b0, ex_ready}, 32'd1);
        tick();
    endtask

    initial begin
        loadVecs[0] = '{F3_B,  32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80};
        loadVecs[1] = '{F3_BU, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080};
        loadVecs[2] = '{F3_HU, 32'h0000_2002, 32'hBEEF_0000, 32'h0000_BEEF};
        loadVecs[3] = '{F3_H,  32'h0000_2002, 32'hBEEF_0000, 32'hFFFF_BEEF};
        loadVecs[4] = '{F3_W,  32'h0000_2004, 32'h89AB_CDEF, 32'h89AB_CDEF};
        loadVecs[5] = '{F3_B,  32'h0000_2003, 32'h7F00_0000, 32'h0000_007F};
        loadVecs[6] = '{F3_H,  32'h0000_2000, 32'h1234_7FFF, 32'h0000_7FFF};

        excVecs[0] = '{1'b1, 1'b0, F3_W,   32'h0000_3002, EXC_MISALIGNED};
        excVecs[1] = '{1'b1, 1'b0, 3'b011, 32'h0000_3000, EXC_ILLEGAL};
        excVecs[2] = '{1'b1, 1'b0, F3_H,   32'h0000_3001, EXC_MISALIGNED};
        excVecs[3] = '{1'b0, 1'b1, F3_H,   32'h0000_3003, EXC_MISALIGNED};
        excVecs[4] = '{1'b0, 1'b1, 3'b100, 32'h0000_3004, EXC_ILLEGAL};
        excVecs[5] = '{1'b1, 1'b1, F3_W,   32'h0000_3008, EXC_ILLEGAL};
        excVecs[6] = '{1'b1, 1'b0, F3_HU,  32'h0000_3005, EXC_MISALIGNED};

        aluVecs[0] = '{32'd1,         5'd3, 1'b1, 1'b1};
        aluVecs[1] = '{32'd2,         5'd4, 1'b1, 1'b1};
        aluVecs[2] = '{32'd3,         5'd0, 1'b1, 1'b0};
        aluVecs[3] = '{32'hCAFE_F00D, 5'd7, 1'b0, 1'b0};

        rst           = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        tick();
        checkOutput("rst ex_ready", {31'b0, ex_ready}, 32'd1);
        checkOutput("rst req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("rst wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst exc_valid", {31'b0, exc_valid}, 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'd0);
        checkOutput("rst wstrb", {28'b0, mem_wstrb}, 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back ALU ops: one writeback per cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, aluVecs[i].result, 32'h0,
                          aluVecs[i].rd, aluVecs[i].regWrite);
            tick();
            checkOutput("alu wb_valid", {31'b0, wb_valid}, 32'd1);
            checkOutput("alu wb_data", wb_data, aluVecs[i].result);
            checkOutput("alu wb_we", {31'b0, wb_we}, {31'b0, aluVecs[i].expWe});
            checkOutput("alu wb_rd", {27'b0, wb_rd}, {27'b0, aluVecs[i].rd});
            checkOutput("alu ex_ready", {31'b0, ex_ready}, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        checkOutput("alu drain wb_valid", {31'b0, wb_valid}, 32'd0);

        // Loads through the full request/response path.
        for (int i = 0; i < 7; i++) begin
            doLoad(loadVecs[i]);
        end

        // Exceptions: single pulse, no memory traffic, stage stays ready.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, excVecs[i].isLoad, excVecs[i].isStore, excVecs[i].funct3,
                          excVecs[i].addr, 32'hFFFF_FFFF, 5'd9, 1'b1);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
            checkOutput("exc valid", {31'b0, exc_valid}, 32'd1);
            checkOutput("exc cause", {30'b0, exc_cause}, {30'b0, excVecs[i].expCause});
            checkOutput("exc addr", exc_addr, excVecs[i].addr);
            checkOutput("exc req_valid", {31'b0, mem_req_valid}, 32'd0);
            checkOutput("exc wb_valid", {31'b0, wb_valid}, 32'd0);
            checkOutput("exc ex_ready", {31'b0, ex_ready}, 32'd1);
            tick();
            checkOutput("exc pulse end", {31'b0, exc_valid}, 32'd0);
            checkOutput("exc no req", {31'b0, mem_req_valid}, 32'd0);
        end

        // SB with ready tied high: 2-cycle completion.
        mem_req_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, F3_B, 32'h0000_1003, 32'h1234_56A5, 5'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("sb req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("sb mem_addr", mem_addr, 32'h0000_1000);
        checkOutput("sb wstrb", {28'b0, mem_wstrb}, 32'h8);
        checkOutput("sb wdata", mem_wdata, 32'hA5A5_A5A5);
        checkOutput("sb we", {31'b0, mem_we}, 32'd1);
        checkOutput("sb wb early", {31'b0, wb_valid}, 32'd0);
        tick();
        mem_req_ready = 1'b0;
        checkOutput("sb wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("sb wb_we", {31'b0, wb_we}, 32'd0);
        checkOutput("sb req drop", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("sb ex_ready", {31'b0, ex_ready}, 32'd1);
        tick();
        checkOutput("sb wb pulse end", {31'b0, wb_valid}, 32'd0);

        // SH stalled by mem_req_ready low for 5 cycles.
        applyStimulus(1'b1, 1'b0, 1'b1, F3_H, 32'h0000_4002, 32'h1234_BEEF, 5'd6, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall req_valid", {31'b0, mem_req_valid}, 32'd1);
            checkOutput("stall mem_addr", mem_addr, 32'h0000_4000);
            checkOutput("stall wstrb", {28'b0, mem_wstrb}, 32'hC);
            checkOutput("stall wdata", mem_wdata, 32'hBEEF_BEEF);
            checkOutput("stall we", {31'b0, mem_we}, 32'd1);
            checkOutput("stall ex_ready", {31'b0, ex_ready}, 32'd0);
            checkOutput("stall wb_valid", {31'b0, wb_valid}, 32'd0);
            tick();
        end
        checkOutput("stall6 req_valid", {31'b0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checkOutput("stall done wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("stall done wb_we", {31'b0, wb_we}, 32'd0);
        checkOutput("stall done req", {31'b0, mem_req_valid}, 32'd0);
        tick();

        // Reset while waiting for load data; a late response must be ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_5000, 32'h0, 5'd8, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checkOutput("resp ex_ready", {31'b0, ex_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst2 ex_ready", {31'b0, ex_ready}, 32'd1);
        checkOutput("rst2 req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("rst2 wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst2 wb_data", wb_data, 32'd0);
        checkOutput("rst2 mem_addr", mem_addr, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h5555_AAAA;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("late rsp wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("late rsp ex_ready", {31'b0, ex_ready}, 32'd1);
        tick();
        checkOutput("late rsp wb_valid2", {31'b0, wb_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_mem_stage.md
Name: riscv_mem_stage

Overview:
- Memory stage directly downstream of the ALU/ALU-control block; consumes its 32-bit result as an effective address (loads/stores) or as a pass-through writeback value (all other ops).
- Drives a single-port valid/ready data-memory interface with byte strobes.
- Formats load data (lane select, sign/zero extension) and presents one writeback beat per accepted op.
- Stalls upstream via ex_ready while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  op from execute is present.
- ex_ready  out  1  stage can accept an op this cycle.
- ex_is_load  in  1  op is a load.
- ex_is_store  in  1  op is a store.
- ex_funct3  in  3  instr[14:12] of the op.
- ex_result  in  32  ALU result: address for memory ops, value otherwise.
- ex_store_data  in  32  rs2 value.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  op writes rd.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_we  out  1  1 = write.
- mem_wstrb  out  4  byte-lane enables (0 for reads).
- mem_wdata  out  32  lane-replicated store data.
- mem_rsp_valid  in  1  read data valid.
- mem_rdata  in  32  read data word.
- wb_valid  out  1  one-cycle writeback/completion pulse.
- wb_we  out  1  register write enable (reg_write && rd!=0).
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  2  01 = misaligned, 10 = illegal funct3.
- exc_addr  out  32  faulting effective address.

Behaviour:
- Reset: state IDLE; every output 0 except ex_ready = 1. Reset mid-transaction abandons it: mem_req_valid drops the following cycle and any pending response is ignored.
- FSM states:
  - IDLE: ex_ready = 1; accepts when ex_valid.
  - REQ: mem_req_valid = 1.
  - RESP: waiting for load data.
- Accept in IDLE:
  - Non-memory op: latch it; next cycle wb_valid = 1, wb_data = ex_result; remain IDLE (1-cycle latency, fully pipelined).
  - Memory op, legal and aligned: latch the operands; go to REQ.
  - Memory op, misaligned or illegal: next cycle exc_valid = 1 with cause and exc_addr; no memory request; no wb_valid; remain IDLE.
  - ex_is_load and ex_is_store both set is illegal (cause 10).
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other funct3 values are illegal.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0. Misalignment takes priority over illegal.
- REQ:
  - mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until the handshake (no retraction).
  - On mem_req_ready, a store goes to IDLE with wb_valid = 1, wb_we = 0 the next cycle.
  - On mem_req_ready, a load goes to RESP.
- RESP:
  - On mem_rsp_valid, the next cycle gives wb_valid = 1 with formatted data; go to IDLE.
  - No timeout.
  - A response arriving in the same cycle as the request handshake is not supported; the memory responds at least 1 cycle after it.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 4'b0011 << addr[1:0].
  - SW: wdata = rs2, wstrb = 4'b1111.
- Load formatting: select the byte at addr[1:0], or the halfword at addr[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW takes the whole word.
- ex_ready = 0 in REQ and RESP. Minimum latency: store 2 cycles, load 3 cycles from accept to wb_valid.
- wb_valid and exc_valid are never asserted together.

Decomposition:
- Shared package riscv_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - exc_cause encodings.
  - mem-stage state enum.
- Sub-module riscv_lsu_align (combinational): store lane/strobe generation and load extraction/extension. The FSM and registers stay in the top module.

Test Plan:
- SB addr 0x1003, rs2 0xA5 -> wstrb 4'b1000, wdata 0xA5A5A5A5, mem_addr 0x1000, wb_valid with wb_we = 0 two cycles after accept (ready tied 1).
- LB addr 0x2001, rdata 0x0000_80_00 -> wb_data 0xFFFFFF80; same access as LBU -> 0x00000080; LHU addr 0x2002, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW addr 0x3002 -> exc_valid, cause 01, exc_addr 0x3002, no mem_req_valid, ex_ready stays 1; funct3 011 load -> cause 10.
- mem_req_ready held 0 for 5 cycles -> request fields stable, ex_ready 0 throughout; completes on the 6th cycle.
- Back-to-back non-memory ops with ex_result 1, 2, 3 -> wb_data 1, 2, 3 on consecutive cycles; rd = 0 -> wb_we = 0.
- rst asserted in RESP -> next cycle IDLE with outputs at reset values; a late mem_rsp_valid produces no wb_valid.
